// File: rtl/dram_stream_packer.sv
// rtl/dram_stream_packer.sv - packs a narrow DRAM read stream into wide memory words
// Beats append MSB-first below the valid bits; completed words are written one cycle later.
module dram_stream_packer #(
  parameter int DATA_IN_BITWIDTH  = 8,
  parameter int DATA_OUT_BITWIDTH = 163,
  parameter int MEM_DEPTH         = 1024,
  parameter int ADDR_BITWIDTH     = 10
) (
  input  logic                         clk_i,
  input  logic                         dram_pack_rst_n_i,
  input  logic                         start_i,
  input  logic [ADDR_BITWIDTH-1:0]     base_addr_i,
  input  logic [ADDR_BITWIDTH:0]       num_words_i,
  input  logic                         flush_i,
  input  logic [DATA_IN_BITWIDTH-1:0]  data_in_i,
  input  logic                         data_valid_i,
  output logic                         data_ready_o,
  output logic [DATA_OUT_BITWIDTH-1:0] mem_data_o,
  output logic [ADDR_BITWIDTH-1:0]     mem_addr_o,
  output logic                         memory_write_enable,
  output logic                         busy_o,
  output logic                         done_o
);
  localparam int ACC_W = DATA_OUT_BITWIDTH + DATA_IN_BITWIDTH - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_FLUSH, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [ACC_W-1:0]             acc_q, acc_d;
  logic [CNT_W-1:0]             bits_q, bits_d;
  logic [ADDR_BITWIDTH:0]       words_q, words_d, num_q, num_d;
  logic [ADDR_BITWIDTH-1:0]     addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_OUT_BITWIDTH-1:0] wr_data_q, wr_data_d;
  logic                         we_q, we_d, last_q, last_d;

  logic                         accept;
  logic [CNT_W-1:0]             shamt;
  logic [CNT_W:0]               bits_sum;
  logic                         word_full;
  logic [ACC_W-1:0]             merged;
  logic [ADDR_BITWIDTH-1:0]     next_addr;

  assign data_ready_o        = (state_q == S_PACK) & ~flush_i & ~last_q;
  assign accept              = data_valid_i & data_ready_o;
  assign busy_o              = (state_q == S_PACK) | (state_q == S_FLUSH);
  assign done_o              = (state_q == S_DONE);
  assign mem_data_o          = wr_data_q;
  assign mem_addr_o          = wr_addr_q;
  assign memory_write_enable = we_q;

  // Valid bits stay MSB-aligned; bits below them are always zero, so OR-merge is safe.
  assign shamt     = CNT_W'(ACC_W - DATA_IN_BITWIDTH) - bits_q;
  assign merged    = acc_q | (ACC_W'(data_in_i) << shamt);
  assign bits_sum  = {1'b0, bits_q} + (CNT_W+1)'(DATA_IN_BITWIDTH);
  assign word_full = bits_sum >= (CNT_W+1)'(DATA_OUT_BITWIDTH);
  assign next_addr = (addr_q == ADDR_BITWIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bits_d    = bits_q;
    words_d   = words_q;
    num_d     = num_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we_d      = 1'b0;
    last_d    = last_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          num_d   = num_words_i;
          acc_d   = '0;
          bits_d  = '0;
          words_d = '0;
          last_d  = 1'b0;
          state_d = (num_words_i == '0) ? S_DONE : S_PACK;
        end
      end
      S_PACK: begin
        if (last_q) begin
          state_d = S_DONE;
        end else if (flush_i) begin
          state_d = S_FLUSH;
        end else if (accept) begin
          if (word_full) begin
            we_d      = 1'b1;
            wr_data_d = merged[ACC_W-1 -: DATA_OUT_BITWIDTH];
            wr_addr_d = addr_q;
            addr_d    = next_addr;
            words_d   = words_q + 1'b1;
            last_d    = (words_q + 1'b1) == num_q;
            acc_d     = merged << DATA_OUT_BITWIDTH;
            bits_d    = CNT_W'(bits_sum - (CNT_W+1)'(DATA_OUT_BITWIDTH));
            // Carry-over past the final word is dropped.
            if ((words_q + 1'b1) == num_q) begin
              acc_d  = '0;
              bits_d = '0;
            end
          end else begin
            acc_d  = merged;
            bits_d = bits_sum[CNT_W-1:0];
          end
        end
      end
      S_FLUSH: begin
        if (bits_q != '0) begin
          we_d      = 1'b1;
          wr_data_d = acc_q[ACC_W-1 -: DATA_OUT_BITWIDTH];
          wr_addr_d = addr_q;
          addr_d    = next_addr;
          words_d   = words_q + 1'b1;
        end
        acc_d   = '0;
        bits_d  = '0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge dram_pack_rst_n_i) begin
    if (!dram_pack_rst_n_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      bits_q    <= '0;
      words_q   <= '0;
      num_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      we_q      <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bits_q    <= bits_d;
      words_q   <= words_d;
      num_q     <= num_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      we_q      <= we_d;
      last_q    <= last_d;
    end
  end
endmodule

// File: tb/tb_dram_stream_packer.sv
// tb/tb_dram_stream_packer.sv - directed self-checking bench for dram_stream_packer
`timescale 1ns/1ps
module tb_dram_stream_packer;
  localparam int AW = 10;
  localparam int OA = 20;
  localparam int OB = 163;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          start_a, flush_a, valid_a, ready_a, we_a, busy_a, done_a;
  logic [AW-1:0] base_a, addr_a;
  logic [AW:0]   num_a;
  logic [7:0]    din_a;
  logic [OA-1:0] data_a;

  logic          start_b, flush_b, valid_b, ready_b, we_b, busy_b, done_b;
  logic [AW-1:0] base_b, addr_b;
  logic [AW:0]   num_b;
  logic [7:0]    din_b;
  logic [OB-1:0] data_b;

  dram_stream_packer #(.DATA_IN_BITWIDTH(8), .DATA_OUT_BITWIDTH(OA), .MEM_DEPTH(1024), .ADDR_BITWIDTH(AW)) u_a (
    .clk_i(clk), .dram_pack_rst_n_i(rst_n), .start_i(start_a), .base_addr_i(base_a),
    .num_words_i(num_a), .flush_i(flush_a), .data_in_i(din_a), .data_valid_i(valid_a),
    .data_ready_o(ready_a), .mem_data_o(data_a), .mem_addr_o(addr_a),
    .memory_write_enable(we_a), .busy_o(busy_a), .done_o(done_a));

  dram_stream_packer #(.DATA_IN_BITWIDTH(8), .DATA_OUT_BITWIDTH(OB), .MEM_DEPTH(1024), .ADDR_BITWIDTH(AW)) u_b (
    .clk_i(clk), .dram_pack_rst_n_i(rst_n), .start_i(start_b), .base_addr_i(base_b),
    .num_words_i(num_b), .flush_i(flush_b), .data_in_i(din_b), .data_valid_i(valid_b),
    .data_ready_o(ready_b), .mem_data_o(data_b), .mem_addr_o(addr_b),
    .memory_write_enable(we_b), .busy_o(busy_b), .done_o(done_b));

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]    beats_a [0:15];
  time           acc_t   [0:15];
  logic [OA-1:0] cap_d   [0:15];
  logic [AW-1:0] cap_ad  [0:15];
  time           cap_t   [0:15];
  int            cap_n = 0;

  always @(negedge clk) begin
    if (we_a && cap_n < 16) begin
      cap_d[cap_n]  = data_a;
      cap_ad[cap_n] = addr_a;
      cap_t[cap_n]  = $time;
      cap_n++;
    end
  end

  function automatic logic [7:0] beat(input int i);
    int v;
    v = (i * 37 + 11) ^ (i >> 3);
    return v[7:0];
  endfunction

  function automatic logic [OB-1:0] exp_word(input int w);
    logic [OB-1:0] r;
    logic [7:0] b;
    int g;
    r = '0;
    for (int j = 0; j < OB; j++) begin
      g = w * OB + j;
      b = beat(g / 8);
      r[OB-1-j] = b[7 - (g % 8)];
    end
    return r;
  endfunction

  task automatic start_job_a(input int base, input int num);
    @(negedge clk);
    cap_n   = 0;
    base_a  = AW'(base);
    num_a   = (AW+1)'(num);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic feed_a(input int n);
    int i;
    int guard;
    logic r;
    i = 0;
    guard = 0;
    while (i < n && guard < 64) begin
      @(negedge clk);
      din_a = beats_a[i];
      valid_a = 1'b1;
      #1 r = ready_a;
      @(posedge clk);
      if (r) begin
        acc_t[i] = $time;
        i++;
      end
      guard++;
    end
    @(negedge clk);
    valid_a = 1'b0;
    n_total++;
    if (i != n) $display("FAIL feed_timeout accepted=%0d required=%0d", i, n);
    else n_pass++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_a = 0; flush_a = 0; valid_a = 0; din_a = 0; base_a = 0; num_a = 0;
    start_b = 0; flush_b = 0; valid_b = 0; din_b = 0; base_b = 0; num_b = 0;
    wait_cycles(2);
    n_total++;
    if ({we_a, ready_a, busy_a, done_a, data_a, addr_a} !== '0)
      $display("FAIL reset_a got we=%b rdy=%b busy=%b done=%b data=%h addr=%0d required all 0",
               we_a, ready_a, busy_a, done_a, data_a, addr_a);
    else n_pass++;
    n_total++;
    if ({we_b, ready_b, busy_b, done_b, data_b, addr_b} !== '0)
      $display("FAIL reset_b got we=%b rdy=%b busy=%b done=%b addr=%0d required all 0",
               we_b, ready_b, busy_b, done_b, addr_b);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    beats_a[0] = 8'hAB; beats_a[1] = 8'hCD; beats_a[2] = 8'hEF; beats_a[3] = 8'h12; beats_a[4] = 8'h34;
    start_job_a(5, 2);
    feed_a(5);
    wait_cycles(2);
    n_total++;
    if (cap_n !== 2) $display("FAIL b2b_count got %0d required 2", cap_n); else n_pass++;
    n_total++;
    if (cap_d[0] !== 20'hABCDE || cap_ad[0] !== 10'd5)
      $display("FAIL b2b_word0 got %h@%0d required abcde@5", cap_d[0], cap_ad[0]);
    else n_pass++;
    n_total++;
    if (cap_t[0] !== acc_t[2] + 5) $display("FAIL b2b_latency0 got t=%0t required t=%0t", cap_t[0], acc_t[2] + 5);
    else n_pass++;
    n_total++;
    if (cap_d[1] !== 20'hF1234 || cap_ad[1] !== 10'd6)
      $display("FAIL b2b_word1 got %h@%0d required f1234@6", cap_d[1], cap_ad[1]);
    else n_pass++;
    n_total++;
    if (cap_t[1] !== acc_t[4] + 5) $display("FAIL b2b_latency1 got t=%0t required t=%0t", cap_t[1], acc_t[4] + 5);
    else n_pass++;
    valid_a = 1'b1;
    #1;
    n_total++;
    if (done_a !== 1'b1 || ready_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL b2b_done got done=%b rdy=%b busy=%b required 1/0/0", done_a, ready_a, busy_a);
    else n_pass++;
    valid_a = 1'b0;
  endtask

  task automatic test_flush;
    logic r;
    beats_a[0] = 8'hAB; beats_a[1] = 8'hCD; beats_a[2] = 8'hEF;
    start_job_a(100, 4);
    feed_a(3);
    flush_a = 1'b1; valid_a = 1'b1; din_a = 8'h12;
    #1 r = ready_a;
    n_total++;
    if (r !== 1'b0) $display("FAIL flush_ready got %b required 0", r); else n_pass++;
    @(negedge clk);
    flush_a = 1'b0; valid_a = 1'b0;
    wait_cycles(3);
    n_total++;
    if (cap_n !== 2) $display("FAIL flush_count got %0d required 2", cap_n); else n_pass++;
    n_total++;
    if (cap_d[0] !== 20'hABCDE || cap_ad[0] !== 10'd100)
      $display("FAIL flush_word0 got %h@%0d required abcde@100", cap_d[0], cap_ad[0]);
    else n_pass++;
    n_total++;
    if (cap_d[1] !== 20'hF0000 || cap_ad[1] !== 10'd101)
      $display("FAIL flush_pad got %h@%0d required f0000@101", cap_d[1], cap_ad[1]);
    else n_pass++;
    n_total++;
    if (done_a !== 1'b1) $display("FAIL flush_done got %b required 1", done_a); else n_pass++;
  endtask

  task automatic test_addr_wrap;
    logic [OA-1:0] ew [0:3];
    logic [AW-1:0] ea [0:3];
    for (int i = 0; i < 10; i++) beats_a[i] = 8'(i + 1);
    ew[0] = 20'h01020; ew[1] = 20'h30405; ew[2] = 20'h06070; ew[3] = 20'h8090A;
    ea[0] = 10'd1022;  ea[1] = 10'd1023;  ea[2] = 10'd0;     ea[3] = 10'd1;
    start_job_a(1022, 4);
    feed_a(10);
    wait_cycles(3);
    n_total++;
    if (cap_n !== 4) $display("FAIL wrap_count got %0d required 4", cap_n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (cap_d[i] !== ew[i] || cap_ad[i] !== ea[i])
        $display("FAIL wrap_word%0d got %h@%0d required %h@%0d", i, cap_d[i], cap_ad[i], ew[i], ea[i]);
      else n_pass++;
    end
    n_total++;
    if (done_a !== 1'b1) $display("FAIL wrap_done got %b required 1", done_a); else n_pass++;
  endtask

  task automatic test_zero_and_ignore;
    start_job_a(40, 0);
    n_total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL zero_done got done=%b busy=%b required 1/0", done_a, busy_a);
    else n_pass++;
    wait_cycles(2);
    n_total++;
    if (cap_n !== 0) $display("FAIL zero_nowrite got %0d writes required 0", cap_n); else n_pass++;
    start_job_a(3, 1);
    n_total++;
    if (busy_a !== 1'b1) $display("FAIL ignore_busy got %b required 1", busy_a); else n_pass++;
    base_a = 10'd9; num_a = 11'd5; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    beats_a[0] = 8'h12; beats_a[1] = 8'h34; beats_a[2] = 8'h56;
    feed_a(3);
    wait_cycles(2);
    n_total++;
    if (cap_n !== 1 || cap_d[0] !== 20'h12345 || cap_ad[0] !== 10'd3)
      $display("FAIL ignore_start got n=%0d %h@%0d required 1 12345@3", cap_n, cap_d[0], cap_ad[0]);
    else n_pass++;
    n_total++;
    if (done_a !== 1'b1) $display("FAIL ignore_done got %b required 1", done_a); else n_pass++;
  endtask

  task automatic test_mid_reset;
    beats_a[0] = 8'hAB; beats_a[1] = 8'hCD; beats_a[2] = 8'hEF;
    start_job_a(0, 2);
    feed_a(3);
    n_total++;
    if (we_a !== 1'b1 || busy_a !== 1'b1) $display("FAIL midrst_pre got we=%b busy=%b required 1/1", we_a, busy_a);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({we_a, ready_a, busy_a, done_a, data_a, addr_a} !== '0)
      $display("FAIL midrst_async got we=%b rdy=%b busy=%b done=%b data=%h addr=%0d required all 0",
               we_a, ready_a, busy_a, done_a, data_a, addr_a);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    beats_a[0] = 8'h11; beats_a[1] = 8'h22; beats_a[2] = 8'h33;
    start_job_a(0, 1);
    feed_a(3);
    wait_cycles(2);
    n_total++;
    if (cap_n !== 1 || cap_d[0] !== 20'h11223 || cap_ad[0] !== 10'd0)
      $display("FAIL midrst_restart got n=%0d %h@%0d required 1 11223@0", cap_n, cap_d[0], cap_ad[0]);
    else n_pass++;
  endtask

  task automatic test_stream;
    int idx;
    int nwr;
    int drops;
    logic r;
    idx = 0; nwr = 0; drops = 0;
    @(negedge clk);
    base_b = 10'd7; num_b = 11'd50; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    din_b = beat(0);
    valid_b = 1'b1;
    for (int cyc = 0; cyc < 3000 && !done_b; cyc++) begin
      if (we_b) begin
        n_total++;
        if (data_b !== exp_word(nwr) || addr_b !== AW'(7 + nwr))
          $display("FAIL stream_word%0d got %h@%0d required %h@%0d", nwr, data_b, addr_b, exp_word(nwr), AW'(7 + nwr));
        else n_pass++;
        nwr++;
      end
      if (!ready_b && !(we_b && nwr == 50)) drops++;
      r = ready_b;
      @(posedge clk);
      #1;
      if (r) begin
        idx++;
        din_b = beat(idx);
      end
      @(negedge clk);
    end
    valid_b = 1'b0;
    n_total++;
    if (nwr !== 50) $display("FAIL stream_count got %0d required 50", nwr); else n_pass++;
    n_total++;
    if (drops !== 0) $display("FAIL stream_ready_drop got %0d required 0", drops); else n_pass++;
    n_total++;
    if (done_b !== 1'b1 || ready_b !== 1'b0) $display("FAIL stream_done got done=%b rdy=%b required 1/0", done_b, ready_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_flush();
    test_addr_wrap();
    test_zero_and_ignore();
    test_mid_reset();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
